// File: rtl/mult_operand_sequencer.sv
// Operand feeder and result collector for the 8x8 Robertson's signed multiplier.
// An operand pair is accepted over a valid/ready handshake and held on the
// multiplier inputs. The multiplier reset is pulsed to start the multiplication.
// The sequencer then waits, with a timeout, for the done flag. The captured
// 16-bit product is presented downstream on a valid/ready handshake.
// Every output is driven straight from a register.
module mult_operand_sequencer #(
  // Cycles mult_reset stays high in LAUNCH after the operands load (1..15).
  parameter int unsigned RST_CYCLES = 1,
  // Cycles WAIT may last before the result is aborted with out_err (2..255).
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  // Upstream operand handshake
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_multiplier,
  input  logic [7:0]  in_multiplicand,
  // Multiplier interface
  output logic        mult_reset,
  output logic [7:0]  mult_multiplier,
  output logic [7:0]  mult_multiplicand,
  input  logic [15:0] mult_product,
  input  logic        mult_done,
  // Downstream result handshake
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic [7:0]  out_multiplier,
  output logic [7:0]  out_multiplicand,
  output logic        out_err,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Terminal values of the shared cycle counter in LAUNCH and WAIT.
  localparam logic [7:0] LAUNCH_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);

  state_t      state_q,       state_d;
  logic [7:0]  cnt_q,         cnt_d;
  logic        in_ready_q,    in_ready_d;
  logic        mult_reset_q,  mult_reset_d;
  logic [7:0]  mult_a_q,      mult_a_d;
  logic [7:0]  mult_b_q,      mult_b_d;
  logic        out_valid_q,   out_valid_d;
  logic [15:0] out_product_q, out_product_d;
  logic [7:0]  out_a_q,       out_a_d;
  logic [7:0]  out_b_q,       out_b_d;
  logic        out_err_q,     out_err_d;
  logic [7:0]  op_count_q,    op_count_d;

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    in_ready_d    = in_ready_q;
    mult_reset_d  = mult_reset_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_err_d     = out_err_q;
    op_count_d    = op_count_q;

    case (state_q)
      ST_IDLE: begin
        // The multiplier sits in reset. Both the drive copy and the echo copy
        // of the operands are loaded together, so they cannot disagree.
        if (in_valid && in_ready_q) begin
          mult_a_d   = in_multiplier;
          mult_b_d   = in_multiplicand;
          out_a_d    = in_multiplier;
          out_b_d    = in_multiplicand;
          in_ready_d = 1'b0;
          cnt_d      = 8'd0;
          state_d    = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        // Reset stays high for RST_CYCLES cycles so the multiplier restarts
        // cleanly on the new operands. Any done flag seen here is stale.
        if (cnt_q == LAUNCH_LAST) begin
          mult_reset_d = 1'b0;
          cnt_d        = 8'd0;
          state_d      = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_WAIT: begin
        // mult_product is sampled only here, and only while done is high.
        // This keeps X values on the product bus away from out_product.
        // Done is tested first, so it wins over a timeout in the same cycle.
        cnt_d = cnt_q + 8'd1;
        if (mult_done) begin
          out_product_d = mult_product;
          out_err_d     = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end else if (cnt_q == WAIT_LAST) begin
          out_product_d = 16'h0000;
          out_err_d     = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Results are frozen until downstream takes them. New operands are
        // accepted only from the following IDLE cycle.
        if (out_ready) begin
          op_count_d   = op_count_q + 8'd1;
          out_valid_d  = 1'b0;
          in_ready_d   = 1'b1;
          mult_reset_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        in_ready_d   = 1'b1;
        mult_reset_d = 1'b1;
        out_valid_d  = 1'b0;
      end
    endcase
  end

  // State register. Reset overrides every input and discards any result in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      in_ready_q    <= 1'b1;
      mult_reset_q  <= 1'b1;
      mult_a_q      <= 8'd0;
      mult_b_q      <= 8'd0;
      out_valid_q   <= 1'b0;
      out_product_q <= 16'h0000;
      out_a_q       <= 8'd0;
      out_b_q       <= 8'd0;
      out_err_q     <= 1'b0;
      op_count_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      mult_reset_q  <= mult_reset_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_err_q     <= out_err_d;
      op_count_q    <= op_count_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign mult_reset        = mult_reset_q;
  assign mult_multiplier   = mult_a_q;
  assign mult_multiplicand = mult_b_q;
  assign out_valid         = out_valid_q;
  assign out_product       = out_product_q;
  assign out_multiplier    = out_a_q;
  assign out_multiplicand  = out_b_q;
  assign out_err           = out_err_q;
  assign op_count          = op_count_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed testbench for mult_operand_sequencer. A small behavioural
// multiplier asserts done a programmable number of cycles after its reset
// drops. It drives X on the product bus while it is held in reset.
module tb_mult_operand_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_multiplier;
  logic [7:0]  in_multiplicand;
  logic        mult_reset;
  logic [7:0]  mult_multiplier;
  logic [7:0]  mult_multiplicand;
  logic [15:0] mult_product;
  logic        mult_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [7:0]  out_multiplier;
  logic [7:0]  out_multiplicand;
  logic        out_err;
  logic [7:0]  op_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_count = 8'd0;

  // Multiplier model controls
  logic model_en    = 1'b0;
  logic model_force = 1'b0;
  int   model_dly   = 0;
  int   model_cnt   = 0;

  mult_operand_sequencer #(.RST_CYCLES(1), .TIMEOUT(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_multiplier     (in_multiplier),
    .in_multiplicand   (in_multiplicand),
    .mult_reset        (mult_reset),
    .mult_multiplier   (mult_multiplier),
    .mult_multiplicand (mult_multiplicand),
    .mult_product      (mult_product),
    .mult_done         (mult_done),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_product       (out_product),
    .out_multiplier    (out_multiplier),
    .out_multiplicand  (out_multiplicand),
    .out_err           (out_err),
    .op_count          (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x;
    logic signed [15:0] y;
    x = {{8{a[7]}}, a};
    y = {{8{b[7]}}, b};
    return 16'(x * y);
  endfunction

  // Behavioural multiplier: counts cycles since its reset was released.
  always @(posedge clk) begin
    if (mult_reset) model_cnt <= 0;
    else if (model_cnt < 1000) model_cnt <= model_cnt + 1;
  end
  assign mult_done    = model_force | (model_en & ~mult_reset & (model_cnt >= model_dly));
  assign mult_product = mult_reset ? 16'hxxxx : smul(mult_multiplier, mult_multiplicand);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one complete operation. Inputs change on falling edges.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int dly,
                        output logic [15:0] prod, output logic err,
                        output logic [7:0] ea, output logic [7:0] eb, output bit ok);
    int t;
    ok = 1'b1;
    model_en = 1'b1;
    model_dly = dly;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) ok = 1'b0;
    in_valid = 1'b1; in_multiplier = a; in_multiplicand = b;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    if (!out_valid) ok = 1'b0;
    prod = out_product; err = out_err; ea = out_multiplier; eb = out_multiplicand;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (ok) exp_count = exp_count + 8'd1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_multiplier = 8'h00; in_multiplicand = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (mult_reset !== 1'b1) begin n_fail++; $display("FAIL reset_mult_reset: got %b expected 1", mult_reset); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    n_checks++; if ({out_product, out_multiplier, out_multiplicand, mult_multiplier, mult_multiplicand} !== 48'h0)
      begin n_fail++; $display("FAIL reset_regs: got %h %h %h %h %h expected zeros", out_product, out_multiplier, out_multiplicand, mult_multiplier, mult_multiplicand); end
    reset = 1'b0;
    @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_reset_mid_op;
    int t;
    bit seen;
    model_en = 1'b1; model_dly = 20;
    in_valid = 1'b1; in_multiplier = 8'h11; in_multiplicand = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (mult_reset && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (mult_reset !== 1'b0) begin n_fail++; $display("FAIL midrst_wait_entry: got mult_reset %b expected 0", mult_reset); end
    repeat (2) @(negedge clk);          // now in the 3rd WAIT cycle
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (mult_reset !== 1'b1) begin n_fail++; $display("FAIL midrst_mult_reset: got %b expected 1", mult_reset); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL midrst_op_count: got %0d expected %0d", op_count, exp_count); end
    n_checks++; if (mult_multiplier !== 8'h00) begin n_fail++; $display("FAIL midrst_operand: got %h expected 00", mult_multiplier); end
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_discard: got out_valid 1 expected 0 after reset"); end
    $display("txn reset mid-operation checked");
  endtask

  task automatic test_basic;
    model_en = 1'b1; model_dly = 9;
    in_valid = 1'b1; in_multiplier = 8'h03; in_multiplicand = 8'hFE;
    @(negedge clk);                      // after handshake edge: LAUNCH
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_launch_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (mult_reset !== 1'b1) begin n_fail++; $display("FAIL basic_launch_mult_reset: got %b expected 1", mult_reset); end
    n_checks++; if ({mult_multiplier, mult_multiplicand} !== 16'h03FE) begin n_fail++; $display("FAIL basic_mult_ops: got %h%h expected 03FE", mult_multiplier, mult_multiplicand); end
    @(negedge clk);                      // first WAIT cycle
    n_checks++; if (mult_reset !== 1'b0) begin n_fail++; $display("FAIL basic_wait_mult_reset: got %b expected 0", mult_reset); end
    repeat (9) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_product !== 16'hFFFA) begin n_fail++; $display("FAIL basic_product: got %h expected FFFA", out_product); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", out_err); end
    n_checks++; if ({out_multiplier, out_multiplicand} !== 16'h03FE) begin n_fail++; $display("FAIL basic_echo: got %h%h expected 03FE", out_multiplier, out_multiplicand); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL basic_op_count: got %0d expected 1", op_count); end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_return_idle: got valid %b ready %b expected 0 1", out_valid, in_ready); end
    $display("txn basic 03 x FE -> %h", out_product);
  endtask

  task automatic test_corners;
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic [15:0] ve [3];
    logic [15:0] p;
    logic e;
    logic [7:0] ea, eb;
    bit ok;
    va[0] = 8'h80; vb[0] = 8'h80; ve[0] = 16'h4000;
    va[1] = 8'h7F; vb[1] = 8'h80; ve[1] = 16'hC080;
    va[2] = 8'h00; vb[2] = 8'hA5; ve[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 5, p, e, ea, eb, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL corner_handshake[%0d]: got no completion expected result", i); end
      n_checks++; if (p !== ve[i] || e !== 1'b0) begin n_fail++; $display("FAIL corner_product[%0d]: got %h err %b expected %h err 0", i, p, e, ve[i]); end
      n_checks++; if (ea !== va[i] || eb !== vb[i]) begin n_fail++; $display("FAIL corner_echo[%0d]: got %h %h expected %h %h", i, ea, eb, va[i], vb[i]); end
      $display("txn corner %h x %h -> %h", va[i], vb[i], p);
    end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL corner_op_count: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_backpressure;
    int t;
    bit bad;
    model_en = 1'b1; model_dly = 3;
    in_valid = 1'b1; in_multiplier = 8'h12; in_multiplicand = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_product !== 16'h03A8 || out_multiplier !== 8'h12 || out_multiplicand !== 8'h34 ||
          in_ready !== 1'b0 || mult_reset !== 1'b0 || out_valid !== 1'b1) begin
        bad = 1'b1;
        $display("FAIL bp_stable[%0d]: got prod %h echo %h %h ready %b mrst %b valid %b expected 03A8 12 34 0 0 1",
                 i, out_product, out_multiplier, out_multiplicand, in_ready, mult_reset, out_valid);
      end
      @(negedge clk);
    end
    n_checks++; if (bad) n_fail++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready %b valid %b expected 1 0", in_ready, out_valid); end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL bp_op_count: got %0d expected %0d", op_count, exp_count); end
    $display("txn backpressure 12 x 34 -> %h", out_product);
  endtask

  // Timeout, then done exactly on the last allowed WAIT cycle.
  task automatic test_timeout;
    int t;
    for (int pass = 0; pass < 2; pass++) begin
      model_en = (pass == 1); model_dly = 63;
      in_valid = 1'b1; in_multiplier = 8'h05; in_multiplicand = 8'hFD;
      @(negedge clk);
      in_valid = 1'b0;
      t = 0;
      while (mult_reset && t < 20) begin @(negedge clk); t++; end
      repeat (63) @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_early[%0d]: got valid %b expected 0", pass, out_valid); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL tmo_valid[%0d]: got valid %b expected 1", pass, out_valid); end
      if (pass == 0) begin
        n_checks++; if (out_err !== 1'b1 || out_product !== 16'h0000) begin n_fail++; $display("FAIL tmo_abort: got err %b prod %h expected 1 0000", out_err, out_product); end
      end else begin
        n_checks++; if (out_err !== 1'b0 || out_product !== 16'hFFF1) begin n_fail++; $display("FAIL tmo_coincide: got err %b prod %h expected 0 FFF1", out_err, out_product); end
      end
      $display("txn timeout pass %0d err %b prod %h", pass, out_err, out_product);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_count = exp_count + 8'd1;
    end
    n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL tmo_op_count: got %0d expected %0d", op_count, exp_count); end
  endtask

  task automatic test_stale_done;
    int t;
    model_en = 1'b1; model_dly = 4; model_force = 1'b1;
    @(negedge clk);                      // idle cycle with done high
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stale_idle: got valid %b expected 0", out_valid); end
    in_valid = 1'b1; in_multiplier = 8'h05; in_multiplicand = 8'h06;
    @(negedge clk);                      // LAUNCH
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stale_launch: got valid %b expected 0", out_valid); end
    @(negedge clk);                      // first WAIT cycle
    n_checks++; if (out_valid !== 1'b0 || mult_reset !== 1'b0) begin n_fail++; $display("FAIL stale_wait_entry: got valid %b mrst %b expected 0 0", out_valid, mult_reset); end
    model_force = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    n_checks++; if (out_product !== 16'h001E || out_err !== 1'b0) begin n_fail++; $display("FAIL stale_product: got %h err %b expected 001E err 0", out_product, out_err); end
    $display("txn stale done 05 x 06 -> %h", out_product);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = exp_count + 8'd1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, ea, eb;
    logic [15:0] p, e;
    logic err;
    bit ok;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 8'd0;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      e = smul(a, b);
      run_op(a, b, int'($urandom_range(0, 12)), p, err, ea, eb, ok);
      n_checks++; if (!ok || p !== e || err !== 1'b0) begin n_fail++; $display("FAIL b2b_product[%0d]: got %h err %b expected %h err 0", i, p, err, e); end
      n_checks++; if (op_count !== exp_count) begin n_fail++; $display("FAIL b2b_op_count[%0d]: got %0d expected %0d", i, op_count, exp_count); end
      $display("txn %0d: %h x %h -> %h count %0d", i, a, b, p, op_count);
    end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL wrap_op_count: got %0d expected 0", op_count); end
  endtask

  initial begin
    test_reset;
    test_reset_mid_op;
    test_basic;
    test_corners;
    test_backpressure;
    test_timeout;
    test_stale_done;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_operand_sequencer.md
Name: mult_operand_sequencer

Overview:
- Upstream feeder and result collector for the 8x8 Robertson's signed multiplier top level.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the multiplier's operand inputs.
- Launches each multiplication by pulsing the multiplier's reset, waits for its done flag, and captures the 16-bit signed product.
- Presents the captured result downstream on a valid/ready handshake, with timeout protection and an operation counter.

Parameters:
- RST_CYCLES, 1: cycles mult_reset is held high in LAUNCH after operands load (legal 1..15).
- TIMEOUT, 64: cycles WAIT may last before aborting with error (legal 2..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_multiplier  in  8  signed multiplier operand.
- in_multiplicand  in  8  signed multiplicand operand.
- mult_reset  out  1  drives the multiplier's reset input.
- mult_multiplier  out  8  operand to the multiplier, registered.
- mult_multiplicand  out  8  operand to the multiplier, registered.
- mult_product  in  16  multiplier product.
- mult_done  in  1  multiplier completion flag (level).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_product  out  16  captured signed product.
- out_multiplier  out  8  echo of the operand used.
- out_multiplicand  out  8  echo of the operand used.
- out_err  out  1  result aborted by timeout.
- op_count  out  8  completed result handshakes, modulo 256.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high, and has priority over every other input.
- Reset values: state=IDLE, in_ready=1, mult_reset=1, all operand/echo/product registers 0, out_valid=0, out_err=0, op_count=0, wait counter 0.
- IDLE: in_ready=1, mult_reset=1.
  - On in_valid&in_ready, latch both operands into the mult_* and out_* operand registers and go to LAUNCH.
- LAUNCH: in_ready=0, mult_reset=1, operands stable.
  - Stay exactly RST_CYCLES cycles, then go to WAIT with the wait counter cleared.
- WAIT: mult_reset=0, and the counter increments each cycle.
  - If mult_done=1, register mult_product into out_product, set out_err=0, go to HOLD.
  - Else if counter==TIMEOUT-1, set out_product=0, out_err=1, go to HOLD.
  - If done and timeout coincide in the same cycle, done wins (out_err=0).
- HOLD: out_valid=1, mult_reset=0, and all out_* are stable while out_valid&!out_ready.
  - On out_ready, increment op_count (wraps 255->0), clear out_valid, go to IDLE.
  - in_ready stays 0 in HOLD; the next operand pair is accepted only in the following IDLE cycle.
- mult_done is ignored in IDLE, LAUNCH and HOLD, so a stale done left over from the previous operation is never captured.
- Latency: operand handshake at edge 0; WAIT first cycle is edge RST_CYCLES+1; out_valid rises on the edge after mult_done is first sampled high in WAIT.
  - Minimum time between accepted operand pairs is RST_CYCLES + (WAIT cycles) + 2.
- Reset mid-operation (any state): outputs return to reset values the next edge, and an in-flight result is discarded without incrementing op_count.
- Arithmetic: no arithmetic is performed on the product; it passes through unmodified as 16-bit two's complement.
- X handling: mult_product may be X outside WAIT and must not propagate to out_product.

Test Plan:
- Basic signed product: in 8'h03 x 8'hFE. Model asserts done 9 cycles into WAIT with product 16'hFFFA. Required: out_valid with out_product=16'hFFFA, out_err=0, echoes 03/FE, op_count=1 after handshake.
- Corner operands: 8'h80 x 8'h80 -> out_product=16'h4000; 8'h7F x 8'h80 -> 16'hC080; 8'h00 x 8'hA5 -> 16'h0000.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD. Required: out_product and echoes constant, in_ready=0, mult_reset=0 throughout. Release out_ready, then in_ready=1 on the next cycle.
- Timeout: model never asserts done, with TIMEOUT=64. Required: out_valid exactly 64 cycles after WAIT entry, out_err=1, out_product=0. Then assert done and timeout in the same cycle and require out_err=0 with the real product captured.
- Stale done and reset mid-operation:
  - Keep mult_done=1 during IDLE/LAUNCH. Required: no capture before WAIT.
  - Assert reset in the 3rd WAIT cycle. Required: IDLE, mult_reset=1, out_valid=0, op_count unchanged on the next edge.
- Counter wrap: run 256 back-to-back operations with random signed operands against a golden signed product. Required: every product matches and op_count reads 0 after the 256th handshake.
